// File: rtl/rx_payload_deframer.sv
// rtl/rx_payload_deframer.sv - parses LEN/SEQ header, packs LEN payload bytes into 32b words, drops padding.
// Optional SEQ gap detection is enabled by defining RX_DEFRAMER_SEQ_CHECK_EN.
module rx_payload_deframer #(
  parameter int MAX_LEN = 1500,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [7:0]       data_in,
  input  logic             eof_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [31:0]      data_out,
  output logic [3:0]       keep_out,
  output logic             last_out,
  output logic             len_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  typedef enum logic [1:0] {HDR, DATA, DRAIN} state_t;

  localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t      state, state_nxt;
  logic [1:0]  hdr_cnt;
  logic [15:0] hdr_len;
  logic [15:0] remaining;
  logic [1:0]  idx;
  logic [31:0] pack;
  logic [31:0] word_nxt;
  logic [3:0]  keep_nxt;
  logic        accept, len_bad;
  logic        emit, flag_len, frame_ok, hdr_good;

  // Backpressure only matters while a word could be produced.
  assign ready_in = (state != DATA) || !(valid_out && !ready_out);
  assign accept   = valid_in && ready_in;
  assign len_bad  = (hdr_len == 16'd0) || (hdr_len > MAX_LEN_W);

  // Merge the incoming byte at slot idx; slots above it are forced to zero.
  always_comb begin
    word_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(idx)) word_nxt[8*i +: 8] = pack[8*i +: 8];
      else if (i == int'(idx)) word_nxt[8*i +: 8] = data_in;
    end
    case (idx)
      2'd0:    keep_nxt = 4'b0001;
      2'd1:    keep_nxt = 4'b0011;
      2'd2:    keep_nxt = 4'b0111;
      default: keep_nxt = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    flag_len  = 1'b0;
    frame_ok  = 1'b0;
    hdr_good  = 1'b0;
    case (state)
      HDR: begin
        if (accept) begin
          if (eof_in) begin
            flag_len = 1'b1;
          end else if (hdr_cnt == 2'd3) begin
            if (len_bad) begin
              flag_len  = 1'b1;
              state_nxt = DRAIN;
            end else begin
              hdr_good  = 1'b1;
              state_nxt = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          emit = (idx == 2'd3) || (remaining == 16'd1) || eof_in;
          if (remaining == 16'd1) begin
            frame_ok  = 1'b1;
            state_nxt = eof_in ? HDR : DRAIN;
          end else if (eof_in) begin
            flag_len  = 1'b1;
            state_nxt = HDR;
          end
        end
      end
      DRAIN: begin
        if (accept && eof_in) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      hdr_cnt    <= 2'd0;
      hdr_len    <= 16'd0;
      remaining  <= 16'd0;
      idx        <= 2'd0;
      pack       <= 32'd0;
      valid_out  <= 1'b0;
      data_out   <= 32'd0;
      keep_out   <= 4'd0;
      last_out   <= 1'b0;
      len_err    <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
    end else begin
      state   <= state_nxt;
      len_err <= flag_len;
      if (flag_len) frames_bad <= frames_bad + CNT_ONE;
      if (frame_ok) frames_ok <= frames_ok + CNT_ONE;
      if (state == HDR && accept) begin
        hdr_cnt <= eof_in ? 2'd0 : hdr_cnt + 2'd1;
        if (hdr_cnt == 2'd0) hdr_len[15:8] <= data_in;
        if (hdr_cnt == 2'd1) hdr_len[7:0]  <= data_in;
      end
      if (hdr_good) begin
        remaining <= hdr_len;
        idx       <= 2'd0;
      end
      if (state == DATA && accept) begin
        remaining <= remaining - 16'd1;
        pack      <= word_nxt;
        idx       <= emit ? 2'd0 : idx + 2'd1;
      end
      if (emit) begin
        valid_out <= 1'b1;
        data_out  <= word_nxt;
        keep_out  <= keep_nxt;
        last_out  <= (remaining == 16'd1) || eof_in;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef RX_DEFRAMER_SEQ_CHECK_EN
  logic [7:0]  seq_hi;
  logic [15:0] seq_exp;

  // Expected SEQ follows every accepted header, so one gap yields one pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_hi  <= 8'd0;
      seq_exp <= 16'd0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (state == HDR && accept && hdr_cnt == 2'd2) seq_hi <= data_in;
      if (hdr_good) begin
        seq_err <= ({seq_hi, data_in} != seq_exp);
        seq_exp <= {seq_hi, data_in} + 16'd1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_payload_deframer.sv
// tb/tb_rx_payload_deframer.sv - directed-vector scoreboard bench for rx_payload_deframer.
module tb_rx_payload_deframer;
  localparam int MAX_LEN = 1500;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_in = 1'b0;
  logic             ready_in;
  logic [7:0]       data_in = 8'd0;
  logic             eof_in = 1'b0;
  logic             valid_out;
  logic             ready_out = 1'b1;
  logic [31:0]      data_out;
  logic [3:0]       keep_out;
  logic             last_out;
  logic             len_err;
  logic             seq_err;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_bad;

  rx_payload_deframer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .eof_in(eof_in), .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .len_err(len_err), .seq_err(seq_err), .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          len_err_cnt = 0;
  int          seq_err_cnt = 0;
  logic        hold_v = 1'b0;
  logic [37:0] hold_snap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word and checks hold stability.
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {26'd0, valid_out, last_out, keep_out},
                      {26'd0, hold_snap[37], hold_snap[0], hold_snap[4:1]});
      if (hold_v) chk("hold_data", data_out, hold_snap[36:5]);
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h keep %h last %b expected none", data_out, keep_out, last_out);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_data", data_out, w.d);
          chk("word_keep", {28'd0, keep_out}, {28'd0, w.k});
          chk("word_last", {31'd0, last_out}, {31'd0, w.l});
        end
      end
      hold_v    = valid_out && !ready_out;
      hold_snap = {valid_out, data_out, keep_out, last_out};
      if (len_err) len_err_cnt++;
      if (seq_err) seq_err_cnt++;
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    valid_in  = 1'b0;
    eof_in    = 1'b0;
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    len_err_cnt = 0;
    seq_err_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    int  n;
    bit  acc;
    valid_in = 1'b1;
    data_in  = d;
    eof_in   = e;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted expected accept", d);
    end
    valid_in = 1'b0;
    eof_in   = 1'b0;
  endtask

  task automatic header(input logic [15:0] len, input logic [15:0] seq);
    send(len[15:8], 1'b0);
    send(len[7:0], 1'b0);
    send(seq[15:8], 1'b0);
    send(seq[7:0], 1'b0);
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.d = d;
    w.k = k;
    w.l = l;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_counts(input string name, input int ok, input int bad, input int le, input int se);
    chk({name, "_frames_ok"}, 32'(frames_ok), ok);
    chk({name, "_frames_bad"}, 32'(frames_bad), bad);
    chk({name, "_len_err"}, len_err_cnt, le);
    chk({name, "_seq_err"}, seq_err_cnt, se);
  endtask

  initial begin
    int seq_exp_pulses;
`ifdef RX_DEFRAMER_SEQ_CHECK_EN
    seq_exp_pulses = 1;
`else
    seq_exp_pulses = 0;
`endif

    // Reset state
    do_reset();
    chk("rst_valid_out", {31'd0, valid_out}, 0);
    chk("rst_keep_out", {28'd0, keep_out}, 0);
    chk("rst_last_out", {31'd0, last_out}, 0);
    chk("rst_len_err", {31'd0, len_err}, 0);
    chk("rst_seq_err", {31'd0, seq_err}, 0);
    chk("rst_ready_in", {31'd0, ready_in}, 1);
    chk_counts("rst", 0, 0, 0, 0);

    // LEN=6 with 40 pad bytes
    push(32'h04030201, 4'hF, 1'b0);
    push(32'h00000605, 4'h3, 1'b1);
    header(16'd6, 16'd0);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    for (int i = 0; i < 40; i++) send(8'hEE, i == 39);
    wait_drain("t1_drain");
    chk_counts("t1", 1, 0, 0, 0);

    // LEN=4 ending on eof, output held 5 cycles, then another frame
    do_reset();
    ready_out = 1'b0;
    push(32'hA4A3A2A1, 4'hF, 1'b1);
    header(16'd4, 16'd0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_held_valid", {31'd0, valid_out}, 1);
    chk("t2_held_data", data_out, 32'hA4A3A2A1);
    ready_out = 1'b1;
    push(32'h0000B2B1, 4'h3, 1'b1);
    header(16'd2, 16'd1);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b1);
    wait_drain("t2_drain");
    chk_counts("t2", 2, 0, 0, 0);

    // eof on header byte 2
    do_reset();
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    send(8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_counts("t3a", 0, 1, 1, 0);
    push(32'h000000C1, 4'h1, 1'b1);
    header(16'd1, 16'd0);
    send(8'hC1, 1'b1);
    wait_drain("t3_drain");
    chk_counts("t3", 1, 1, 1, 0);

    // LEN=10 truncated after 5 payload bytes
    do_reset();
    push(32'hD4D3D2D1, 4'hF, 1'b0);
    push(32'h000000D5, 4'h1, 1'b1);
    header(16'd10, 16'd0);
    for (int i = 1; i <= 5; i++) send(8'(8'hD0 + i), i == 5);
    wait_drain("t4_drain");
    chk_counts("t4", 0, 1, 1, 0);

    // LEN=0 and LEN=MAX_LEN+1 drained, then a good frame with SEQ 0
    do_reset();
    header(16'd0, 16'd0);
    for (int i = 0; i < 3; i++) send(8'h55, i == 2);
    header(16'(MAX_LEN + 1), 16'd0);
    for (int i = 0; i < 2; i++) send(8'h66, i == 1);
    repeat (3) @(posedge clk);
    #1;
    chk_counts("t5a", 0, 2, 2, 0);
    push(32'h00332211, 4'h7, 1'b1);
    header(16'd3, 16'd0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    wait_drain("t5_drain");
    chk_counts("t5", 1, 2, 2, 0);

    // SEQ 0,1,3,4
    do_reset();
    push(32'h00001000, 4'h3, 1'b1);
    push(32'h00001101, 4'h3, 1'b1);
    push(32'h00001303, 4'h3, 1'b1);
    push(32'h00001404, 4'h3, 1'b1);
    header(16'd2, 16'd0); send(8'h00, 1'b0); send(8'h10, 1'b1);
    header(16'd2, 16'd1); send(8'h01, 1'b0); send(8'h11, 1'b1);
    header(16'd2, 16'd3); send(8'h03, 1'b0); send(8'h13, 1'b1);
    header(16'd2, 16'd4); send(8'h04, 1'b0); send(8'h14, 1'b1);
    wait_drain("t6_drain");
    chk_counts("t6", 4, 0, 0, seq_exp_pulses);

    // Reset mid-frame, then a fresh frame
    do_reset();
    header(16'd8, 16'd0);
    send(8'h77, 1'b0);
    send(8'h78, 1'b0);
    do_reset();
    chk("t7_valid_after_rst", {31'd0, valid_out}, 0);
    push(32'h0000005A, 4'h1, 1'b1);
    header(16'd1, 16'd0);
    send(8'h5A, 1'b1);
    wait_drain("t7_drain");
    chk_counts("t7", 1, 0, 0, 0);

    // LEN=MAX_LEN exactly, eof on last payload byte
    do_reset();
    for (int k = 0; k < MAX_LEN / 4; k++)
      push({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 4'hF, k == MAX_LEN / 4 - 1);
    header(16'(MAX_LEN), 16'd0);
    for (int i = 0; i < MAX_LEN; i++) send(8'(i), i == MAX_LEN - 1);
    wait_drain("t8_drain");
    chk_counts("t8", 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
